apb4_reg_bridge: RTL and testbench
==================================

APB4_REG_BRIDGE -- requirements
Module: apb4_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: APB paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width. Legal values are 8, 16, 32 and 64.
REQ-003 SHALL have parameter BUS_ADDR_WIDTH, default 8: register-bus address width, at most ADDR_WIDTH.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before abort. Minimum value is 1.
REQ-005 SHALL have ports clk in 1 (clock) and rst in 1 (reset, asynchronous, active-high), listed first.
REQ-006 SHALL have APB ports:
- psel, penable, pwrite: in 1
- paddr: in ADDR_WIDTH
- pwdata: in DATA_WIDTH
- pstrb: in DATA_WIDTH/8
- pready, pslverr: out 1
- prdata: out DATA_WIDTH
REQ-007 SHALL have bus-request ports:
- o_bus_req, o_bus_req_is_wr: out 1
- o_bus_addr: out BUS_ADDR_WIDTH
- o_bus_wr_data, o_bus_wr_biten: out DATA_WIDTH
REQ-008 SHALL have bus-response ports:
- i_bus_req_stall_wr, i_bus_req_stall_rd: in 1, target busy
- i_bus_rd_ack, i_bus_rd_err, i_bus_wr_ack, i_bus_wr_err: in 1
- i_bus_rd_data: in DATA_WIDTH

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT, DONE. All outputs registered.
REQ-010 IDLE: on psel=1 && penable=0, SHALL latch pwrite, paddr, pwdata and pstrb.
- Address in range (paddr[ADDR_WIDTH-1:BUS_ADDR_WIDTH]==0): go to REQ.
- Address out of range: go to DONE with error, no bus request issued.
REQ-011 REQ: o_bus_req SHALL be 1 with the latched fields. o_bus_req_is_wr=pwrite. o_bus_addr=paddr[BUS_ADDR_WIDTH-1:0].
REQ-012 REQ: while the stall input matching the direction is 1, SHALL hold o_bus_req and all fields stable. The first unstalled cycle is the issue cycle; next state is WAIT, or DONE if an ack arrives in that cycle.
REQ-013 o_bus_req SHALL be 0 in every state except REQ. Exactly one issue per APB transfer.
REQ-014 Write biten: each pstrb[i] SHALL be replicated onto o_bus_wr_biten[8i+7:8i]. Reads: biten=0 and wr_data=0.
REQ-015 Ack rules:
- Only the ack/err pair matching the direction SHALL be honoured.
- Mismatched acks are ignored.
- Acks are ignored in IDLE and DONE.
REQ-016 On a matching ack in the issue cycle or in WAIT:
- SHALL latch read data into prdata (reads only), else prdata=0.
- SHALL latch err into pslverr.
- Go to DONE.
REQ-017 DONE: pready=1 for exactly one cycle, with prdata/pslverr valid. Next state IDLE. pready, pslverr and prdata SHALL be 0 in all other states.
REQ-018 Minimum latency: setup cycle, then REQ with same-cycle ack, then DONE. This gives one APB wait state. Each stall or WAIT cycle adds one.
REQ-019 If psel drops before DONE:
- SHALL finish any bus request already issued.
- SHALL discard the response and go to IDLE without asserting pready.
- In REQ before issue, SHALL drop o_bus_req and go to IDLE.
REQ-020 Back-to-back transfers: a new setup SHALL be accepted in IDLE the cycle after DONE.

Reset
REQ-021 rst SHALL force state IDLE, zero all outputs and latches, and clear the timeout counter, effective immediately mid-transfer.
REQ-022 After rst deasserts, the first transfer SHALL be accepted on the next setup cycle.

Configuration
REQ-023 Macro APB4_REG_BRIDGE_TIMEOUT_EN.
- Defined: a counter SHALL count WAIT cycles. When it reaches TIMEOUT_CYCLES, go to DONE with pslverr=1 and prdata=0. A later ack SHALL be ignored.
- Undefined: no counter is compiled in, and WAIT lasts until an ack.

Verification
REQ-024 Read 0x04, rd_ack same cycle as issue, rd_data=0xDEADBEEF -> o_bus_req 1 cycle, pready one cycle later, prdata=0xDEADBEEF, pslverr=0.
REQ-025 Write 0x08, pwdata=0x12345678, pstrb=0b0101, stall_wr held 3 cycles -> o_bus_req held 4 cycles, biten=0x00FF00FF, pready after wr_ack.
REQ-026 Read paddr=0x100 (BUS_ADDR_WIDTH=8) -> no o_bus_req, pready with pslverr=1, prdata=0.
REQ-027 TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> pready+pslverr after 4 WAIT cycles. A late ack is ignored and the next transfer is correct.
REQ-028 Write with wr_err=1 and a simultaneous stray rd_ack -> pslverr=1. rst asserted in WAIT -> all outputs 0 that cycle, FSM in IDLE.

Source files
------------

// File: rtl/apb4_reg_bridge.sv
// APB4 slave to register-bus bridge with a registered IDLE/REQ/WAIT/DONE FSM.
// Optional WAIT timeout compiled in with `define APB4_REG_BRIDGE_TIMEOUT_EN.
module apb4_reg_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pready,
  output logic                      pslverr,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      o_bus_req,
  output logic                      o_bus_req_is_wr,
  output logic [BUS_ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0]     o_bus_wr_data,
  output logic [DATA_WIDTH-1:0]     o_bus_wr_biten,
  input  logic                      i_bus_req_stall_wr,
  input  logic                      i_bus_req_stall_rd,
  input  logic                      i_bus_rd_ack,
  input  logic                      i_bus_rd_err,
  input  logic                      i_bus_wr_ack,
  input  logic                      i_bus_wr_err,
  input  logic [DATA_WIDTH-1:0]     i_bus_rd_data,
  output logic [1:0]                state_dbg
);

  // Handshake: o_bus_req is a valid held with stable fields until a cycle in which
  // the direction-matching stall is low (the single issue cycle); pready is high for
  // exactly one cycle and completes the APB access phase.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t                    state, state_n;
  logic                      aborted, aborted_n;
  logic                      req_n, is_wr_n, pready_n, pslverr_n;
  logic [BUS_ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0]     wdata_n, biten_n, prdata_n;
  logic [DATA_WIDTH-1:0]     strb_mask, resp_data;
  logic                      in_range, stall, ack, err, timeout;

  assign state_dbg = state;
  assign in_range  = ((paddr >> BUS_ADDR_WIDTH) == '0);
  assign stall     = o_bus_req_is_wr ? i_bus_req_stall_wr : i_bus_req_stall_rd;
  assign ack       = o_bus_req_is_wr ? i_bus_wr_ack : i_bus_rd_ack;
  assign err       = o_bus_req_is_wr ? i_bus_wr_err : i_bus_rd_err;
  assign resp_data = o_bus_req_is_wr ? '0 : i_bus_rd_data;

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) strb_mask[8*i +: 8] = {8{pstrb[i]}};
  end

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    else                    wait_cnt <= '0;
  end

  assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    aborted_n = aborted;
    req_n     = 1'b0;
    is_wr_n   = o_bus_req_is_wr;
    addr_n    = o_bus_addr;
    wdata_n   = o_bus_wr_data;
    biten_n   = o_bus_wr_biten;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    case (state)
      IDLE: begin
        aborted_n = 1'b0;
        if (psel && !penable) begin
          is_wr_n = pwrite;
          addr_n  = paddr[BUS_ADDR_WIDTH-1:0];
          wdata_n = pwrite ? pwdata : '0;
          biten_n = pwrite ? strb_mask : '0;
          if (in_range) begin
            state_n = REQ;
            req_n   = 1'b1;
          end else begin
            state_n   = DONE;
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
          end
        end
      end
      REQ: begin
        if (stall) begin
          // Not yet issued: an abandoned transfer can simply be withdrawn.
          if (psel) req_n = 1'b1;
          else      state_n = IDLE;
        end else if (ack) begin
          if (psel) begin
            state_n   = DONE;
            pready_n  = 1'b1;
            pslverr_n = err;
            prdata_n  = resp_data;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n   = WAIT;
          aborted_n = !psel;
        end
      end
      WAIT: begin
        if (ack || timeout) begin
          if (psel && !aborted) begin
            state_n   = DONE;
            pready_n  = 1'b1;
            pslverr_n = ack ? err : 1'b1;
            prdata_n  = ack ? resp_data : '0;
          end else begin
            state_n = IDLE;
          end
        end else if (!psel) begin
          aborted_n = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      aborted         <= 1'b0;
      o_bus_req       <= 1'b0;
      o_bus_req_is_wr <= 1'b0;
      o_bus_addr      <= '0;
      o_bus_wr_data   <= '0;
      o_bus_wr_biten  <= '0;
      pready          <= 1'b0;
      pslverr         <= 1'b0;
      prdata          <= '0;
    end else begin
      state           <= state_n;
      aborted         <= aborted_n;
      o_bus_req       <= req_n;
      o_bus_req_is_wr <= is_wr_n;
      o_bus_addr      <= addr_n;
      o_bus_wr_data   <= wdata_n;
      o_bus_wr_biten  <= biten_n;
      pready          <= pready_n;
      pslverr         <= pslverr_n;
      prdata          <= prdata_n;
    end
  end

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Directed bench for apb4_reg_bridge: vector table plus hand-written corner sequences.
module tb_apb4_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        o_bus_req, o_bus_req_is_wr;
  logic [7:0]  o_bus_addr;
  logic [31:0] o_bus_wr_data, o_bus_wr_biten;
  logic        stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  logic [31:0] rd_data;
  logic [1:0]  state_dbg;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [32:0] exp_q[$];

  apb4_reg_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BUS_ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .o_bus_req(o_bus_req), .o_bus_req_is_wr(o_bus_req_is_wr), .o_bus_addr(o_bus_addr),
    .o_bus_wr_data(o_bus_wr_data), .o_bus_wr_biten(o_bus_wr_biten),
    .i_bus_req_stall_wr(stall_wr), .i_bus_req_stall_rd(stall_rd),
    .i_bus_rd_ack(rd_ack), .i_bus_rd_err(rd_err),
    .i_bus_wr_ack(wr_ack), .i_bus_wr_err(wr_err),
    .i_bus_rd_data(rd_data), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          stall;
    int          wt;
    logic        err;
    logic        stray;
    logic [31:0] rdata;
    logic        b2b;
    logic        oor;
    logic [31:0] exp_biten;
    logic [31:0] exp_wdata;
    logic [31:0] exp_prdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_resp(input logic wr, input logic stl, input logic ak, input logic er,
                            input logic stray, input logic [31:0] rdata);
    stall_wr = 0; stall_rd = 0; rd_ack = 0; rd_err = 0; wr_ack = 0; wr_err = 0; rd_data = 0;
    if (wr) begin
      stall_wr = stl; wr_ack = ak; wr_err = ak & er;
      if (stray) begin stall_rd = 1; rd_ack = 1; rd_err = 1; rd_data = 32'h5555AAAA; end
    end else begin
      stall_rd = stl; rd_ack = ak; rd_err = ak & er; rd_data = rdata;
      if (stray) begin stall_wr = 1; wr_ack = 1; wr_err = 1; end
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_pready"},  pready, 0);
    chk({tag, "_pslverr"}, pslverr, 0);
    chk({tag, "_prdata"},  prdata, 0);
    chk({tag, "_req"},     o_bus_req, 0);
    chk({tag, "_is_wr"},   o_bus_req_is_wr, 0);
    chk({tag, "_addr"},    o_bus_addr, 0);
    chk({tag, "_wdata"},   o_bus_wr_data, 0);
    chk({tag, "_biten"},   o_bus_wr_biten, 0);
    chk({tag, "_state"},   state_dbg, 0);
  endtask

  // One APB transfer; starts and ends on a falling edge, acting as bus target too.
  task automatic do_xfer(input vec_t v);
    logic [32:0] exp;
    exp_q.push_back({v.exp_err, v.exp_prdata});
    psel = 1; penable = 0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata; pstrb = v.strb;
    drive_resp(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    penable = 1;
    if (!v.oor) begin
      for (int k = 0; k <= v.stall; k++) begin
        chk("req_on", o_bus_req, 1);
        chk("req_is_wr", o_bus_req_is_wr, v.wr);
        chk("req_addr", o_bus_addr, v.addr[7:0]);
        chk("req_wdata", o_bus_wr_data, v.exp_wdata);
        chk("req_biten", o_bus_wr_biten, v.exp_biten);
        chk("req_pready", pready, 0);
        drive_resp(v.wr, k < v.stall, (k == v.stall) && (v.wt == 0), v.err, v.stray, v.rdata);
        @(negedge clk);
      end
      for (int w = 0; w < v.wt; w++) begin
        chk("wait_req", o_bus_req, 0);
        chk("wait_pready", pready, 0);
        chk("wait_prdata", prdata, 0);
        drive_resp(v.wr, 0, w == v.wt - 1, v.err, v.stray, v.rdata);
        @(negedge clk);
      end
    end
    drive_resp(0, 0, 0, 0, 0, 0);
    chk("done_req", o_bus_req, 0);
    chk("done_pready", pready, 1);
    chk("done_state", state_dbg, 3);
    exp = exp_q.pop_front();
    chk("done_pslverr", pslverr, exp[32]);
    chk("done_prdata", prdata, exp[31:0]);
    @(negedge clk);
    chk("post_pready", pready, 0);
    chk("post_state", state_dbg, 0);
  endtask

  task automatic idle_cycle();
    psel = 0; penable = 0;
    drive_resp(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_pready", pready, 0);
  endtask

  initial begin
    vec_t lw;
    //          wr    addr          wdata         strb   st wt err  stray rdata         b2b  oor  biten         wdata         prdata        err
    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h12345678, 4'h5, 3, 0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h12345678, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 0, 0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[3] = '{1'b1, 32'h0000_0010, 32'hA5A5A5A5, 4'hF, 0, 1, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h0000_00FF, 32'h0,        4'h0, 0, 2, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h11223344, 4'h8, 1, 3, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'hFF000000, 32'h11223344, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 32'h0000_003C, 32'h0,        4'h0, 2, 1, 1'b0, 1'b0, 32'h0BADF00D, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0BADF00D, 1'b0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h0000FFFF, 4'h3, 0, 0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[8] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_0002, 32'h77777777, 4'hF, 0, 0, 1'b0, 1'b0, 32'h01020304, 1'b0, 1'b0, 32'h0,        32'h0,        32'h01020304, 1'b0};

    // reset
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    drive_resp(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_idle_outs("reset");
    rst = 0;
    @(negedge clk);
    chk("after_reset_state", state_dbg, 0);

    for (int i = 0; i < 10; i++) begin
      do_xfer(vecs[i]);
      if (!vecs[i].b2b) idle_cycle();
    end

    // psel withdrawn while the request is still stalled
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h0000BEEF; pstrb = 4'h3;
    @(negedge clk);
    chk("drop_stall_req", o_bus_req, 1);
    stall_wr = 1; psel = 0; penable = 0;
    @(negedge clk);
    chk("drop_stall_req_off", o_bus_req, 0);
    chk("drop_stall_state", state_dbg, 0);
    chk("drop_stall_pready", pready, 0);
    stall_wr = 0;
    @(negedge clk);
    chk("drop_stall_no_issue", o_bus_req, 0);

    // psel withdrawn after issue: response must be swallowed
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h18; pwdata = 0; pstrb = 0;
    @(negedge clk);
    penable = 1;
    chk("drop_wait_req", o_bus_req, 1);
    @(negedge clk);
    chk("drop_wait_state", state_dbg, 2);
    psel = 0; penable = 0;
    @(negedge clk);
    chk("drop_wait_hold", state_dbg, 2);
    chk("drop_wait_pready", pready, 0);
    rd_ack = 1; rd_data = 32'h13572468;
    @(negedge clk);
    drive_resp(0, 0, 0, 0, 0, 0);
    chk("drop_resp_state", state_dbg, 0);
    chk("drop_resp_pready", pready, 0);
    chk("drop_resp_prdata", prdata, 0);
    @(negedge clk);
    chk("drop_resp_late", pready, 0);

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
    // no ack: abort after exactly four WAIT cycles, late ack ignored
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h0C; pwdata = 0; pstrb = 0;
    @(negedge clk);
    penable = 1;
    chk("to_req", o_bus_req, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_state", state_dbg, 2);
      chk("to_wait_pready", pready, 0);
      @(negedge clk);
    end
    chk("to_done_pready", pready, 1);
    chk("to_done_pslverr", pslverr, 1);
    chk("to_done_prdata", prdata, 0);
    rd_ack = 1; rd_data = 32'h99999999;
    @(negedge clk);
    chk("to_late_pready", pready, 0);
    chk("to_late_state", state_dbg, 0);
    psel = 0; penable = 0;
    @(negedge clk);
    chk("to_late2_pready", pready, 0);
    chk("to_late2_state", state_dbg, 0);
    drive_resp(0, 0, 0, 0, 0, 0);
    do_xfer(vecs[0]);
    idle_cycle();
`else
    // long WAIT with no timeout logic: response arrives after seven cycles
    lw = vecs[0];
    lw.addr = 32'h0C; lw.wt = 7; lw.rdata = 32'h76543210; lw.exp_prdata = 32'h76543210;
    do_xfer(lw);
    idle_cycle();
`endif

    // asynchronous reset while a write is waiting for its ack
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h1C; pwdata = 32'hAA55AA55; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    chk("rst_req", o_bus_req, 1);
    @(negedge clk);
    chk("rst_wait_state", state_dbg, 2);
    chk("rst_wait_addr", o_bus_addr, 8'h1C);
    #2 rst = 1;
    #1 chk_idle_outs("rst_wait");
    @(negedge clk);
    rst = 0; psel = 0; penable = 0;
    @(negedge clk);
    chk("rst_release_state", state_dbg, 0);
    do_xfer(vecs[0]);
    idle_cycle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
